pulse_stretcher_mc: RTL

//  Multi-channel, runtime-programmable pulse stretcher. Used for LEDs, buzzers and

---
 rtl/pulse_stretcher_mc_pkg.sv | 13 +
 rtl/pulse_stretcher_mc_if.sv | 24 ++
 rtl/pulse_stretcher_mc_chan.sv | 76 +++++++
 rtl/pulse_stretcher_mc.sv | 49 ++++
 4 files changed

// File: rtl/pulse_stretcher_mc_pkg.sv
// Shared types and defaults for the multi-channel pulse stretcher.
package pulse_stretcher_mc_pkg;

    // Per-channel FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } chan_state_e;

    localparam int unsigned DEF_NCH = 4;
    localparam int unsigned DEF_CW  = 17;

endpackage

// File: rtl/pulse_stretcher_mc_if.sv
// Event/stretched-output bundle between event sources and the stretcher.
interface pulse_stretcher_mc_if
    import pulse_stretcher_mc_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH,
    parameter int unsigned CW  = DEF_CW
);
    logic [NCH-1:0] original;
    logic [CW-1:0]  len;
    logic           retrig;
    logic [NCH-1:0] extended;
    logic [NCH-1:0] done;
    logic           busy;

    modport master (
        output original, len, retrig,
        input  extended, done, busy
    );

    modport slave (
        input  original, len, retrig,
        output extended, done, busy
    );
endinterface

// File: rtl/pulse_stretcher_mc_chan.sv
// One stretcher channel: turns a trigger into a len_eff-cycle high pulse.
module pulse_stretch_chan
    import pulse_stretcher_mc_pkg::*;
#(
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trig,
    input  logic [CW-1:0] len_eff,
    input  logic          retrig,
    output logic          extended,
    output logic          done,
    output logic          hold
);

    chan_state_e   state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] reload;
    logic          done_q, done_d;
    logic          ext_c;

    assign reload = len_eff - CW'(1);

    // State, remaining-count and done strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Next-state, countdown and output decode
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    rem_d   = reload;
                    state_d = (reload != '0) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (trig && retrig) begin
                    rem_d   = reload;
                    state_d = (reload != '0) ? ST_HOLD : ST_IDLE;
                end else if (rem_q == CW'(1)) begin
                    rem_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_q - CW'(1);
                end
            end
            default: begin
                rem_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        // Zero-latency output; forced low while reset is held.
        ext_c  = ~reset & (trig | (state_q == ST_HOLD));
        // Strobe once the high phase ends: only registered state is known here,
        // so an IDLE re-arm in the following cycle cannot be foreseen.
        done_d = ext_c & (state_d == ST_IDLE);
    end

    assign extended = ext_c;
    assign done     = done_q;
    assign hold     = (state_q == ST_HOLD);

endmodule

// File: rtl/pulse_stretcher_mc.sv
// Multi-channel pulse stretcher: trigger detection, length clamp, busy reduce.
module pulse_stretcher_mc
    import pulse_stretcher_mc_pkg::*;
#(
    parameter int unsigned NCH       = DEF_NCH,
    parameter int unsigned CW        = DEF_CW,
    parameter bit          EDGE_TRIG = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    pulse_stretcher_mc_if.slave  bus
);

    logic [NCH-1:0] orig_q;
    logic [NCH-1:0] trig;
    logic [NCH-1:0] hold;
    logic [CW-1:0]  len_eff;

    // Delayed copy of the raw inputs for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            orig_q <= '0;
        end else begin
            orig_q <= bus.original;
        end
    end

    // Trigger select and zero-length clamp
    always_comb begin
        trig    = EDGE_TRIG ? (bus.original & ~orig_q) : bus.original;
        len_eff = (bus.len == '0) ? CW'(1) : bus.len;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pulse_stretch_chan #(.CW(CW)) u_chan (
            .clk      (clk),
            .reset    (reset),
            .trig     (trig[i]),
            .len_eff  (len_eff),
            .retrig   (bus.retrig),
            .extended (bus.extended[i]),
            .done     (bus.done[i]),
            .hold     (hold[i])
        );
    end

    assign bus.busy = |hold;

endmodule
